clusterv_flash_ctrl: RTL and testbench
======================================

// Module: clusterv_flash_ctrl
// PURPOSE
//  Wishbone-to-SPI-flash read controller that shares the single SoC flash port (flash_sck/csn/sdo/sdi)
//  between two Wishbone initiators: i0 = core instruction fetch, i1 = mgmt target path.
//  Round-robin arbitrates requests, then sequences one SPI READ per 32-bit Wishbone read.
//  Sits in clusterv_soc between the fetch/mgmt interconnect and the flash pins.
// PARAMETERS
//  FLASH_AW   24  flash byte-address bits sent on SPI (24 only supported value)
//  CLK_DIV    1   sck half-period in clock cycles; legal range 1..15
// PORTS
//  clock          in   1   system clock; all logic on posedge
//  reset          in   1   synchronous, active-high reset
//  i0_adr         in   32  initiator 0 byte address (bits [1:0] ignored)
//  i0_cyc/i0_stb  in   1   initiator 0 Wishbone cycle/strobe
//  i0_we          in   1   initiator 0 write enable
//  i0_sel         in   4   initiator 0 byte selects (ignored; full word returned)
//  i0_dat_r       out  32  initiator 0 read data, valid with i0_ack
//  i0_ack/i0_err  out  1   initiator 0 single-cycle ack / error pulse
//  i1_*           --   --  identical set for initiator 1 (mgmt)
//  flash_sck      out  1   SPI clock, mode 0 (idle low)
//  flash_csn      out  1   SPI chip select, active low
//  flash_sdo      out  1   SPI MOSI
//  flash_sdi      in   1   SPI MISO
// BEHAVIOUR
//  Reset: flash_csn=1, flash_sck=0, flash_sdo=0, all ack/err=0, dat_r=0, state=IDLE, last_grant=1.
//  Reset mid-transfer: next cycle csn=1, sck=0, counters cleared, no ack for aborted request.
//  FSM: IDLE -> CMD(8b) -> ADDR(24b) -> [DUMMY] -> DATA(32b) -> ACK -> GAP -> IDLE.
//  IDLE: request = cyc&stb. Both requesting -> grant the one != last_grant; single -> grant it.
//   Grant and adr latched in IDLE cycle (cycle 0); csn falls at cycle 1.
//  Write (we=1) on granted port: err pulse 1 cycle at cycle 1, no SPI activity, return to IDLE.
//  SPI: mode 0, MSB first. sdo updates while sck low; sdi sampled on sck rising edge.
//   Each bit = 2*CLK_DIV clocks (CLK_DIV low, CLK_DIV high). sck low while csn high.
//   CMD = 8'h03; ADDR = {adr[23:2],2'b00}; DATA 4 bytes, byte n -> dat_r[8n+7:8n] (little-endian word).
//  Latency: ack pulse at cycle 1 + 64*2*CLK_DIV (CLK_DIV=1 -> cycle 129); csn rises same cycle.
//  Ack only if granted cyc&stb still high at ACK; else data discarded silently (no retry).
//  GAP: csn high >= 2*CLK_DIV cycles before next grant; requests arriving in GAP wait.
//  last_grant updated at grant; non-granted port sees ack=0/err=0 and must hold stb.
//  Bit counter 7-bit, saturates never; wraps to 0 at each phase boundary.
// CONFIGURATION
//  CLUSTERV_FLASH_FAST_READ_EN defined: CMD = 8'h0B, DUMMY phase of 8 sck cycles (sdo=0) after
//   ADDR; ack at cycle 1 + 72*2*CLK_DIV.
//  Undefined: CMD = 8'h03, no DUMMY state; latency as above.
// STRUCTURE
//  Package clusterv_flash_pkg: state enum (IDLE,CMD,ADDR,DUMMY,DATA,ACK,GAP), opcode constants
//   FLASH_CMD_READ=8'h03, FLASH_CMD_FAST_READ=8'h0B, phase bit lengths.
//  Sub-module clusterv_flash_arb: 2-way round-robin arbiter (req[1:0], enable, gnt[1:0], last_grant).
//  Top: SPI sequencer, sck divider counter, shift registers, Wishbone response muxing.
// TESTING
//  1. After reset i0 read adr=0x100, flash word bytes 11,22,33,44 -> sdo shows 0x03,0x000100;
//     i0_ack at cycle 129, i0_dat_r=0x44332211, csn high after.
//  2. i0 and i1 stb same cycle from reset -> i0 served first, i1 served after GAP; repeat both
//     -> order alternates i1? no: i0,i1,i0,i1 strictly alternating.
//  3. i1 write adr=0x0 -> i1_err one cycle at cycle 1, csn stays 1, no sck edges.
//  4. CLK_DIV=3, i0 read -> sck period 6 clocks, ack at cycle 385, data matches model.
//  5. reset asserted during DATA phase -> next cycle csn=1, sck=0, no ack; new read then succeeds.
//  6. i0 drops cyc mid-transfer -> SPI completes, no i0_ack; FAST_READ build: 8 dummy clocks, ack cycle 145.

Source files
------------

// File: rtl/clusterv_flash_pkg.sv
// Shared types and constants for the clusterv SPI flash read controller.
package clusterv_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ACK,
    GAP
  } flash_state_e;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

  localparam logic [6:0] CMD_BITS   = 7'd8;
  localparam logic [6:0] ADDR_BITS  = 7'd24;
  localparam logic [6:0] DUMMY_BITS = 7'd8;
  localparam logic [6:0] DATA_BITS  = 7'd32;

  // Flash streams byte 0 first; the Wishbone word is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/clusterv_flash_if.sv
// Wishbone classic single-word port between one initiator and the flash controller.
interface clusterv_flash_if;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (output adr, cyc, stb, we, sel, input dat_r, ack, err);
  modport slave  (input adr, cyc, stb, we, sel, output dat_r, ack, err);
endinterface

// File: rtl/clusterv_flash_arb.sv
// Two-way round-robin arbiter; gnt is combinational, last_grant is updated on every grant.
module clusterv_flash_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       last_grant
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Reset to 1 so initiator 0 wins the first contended grant.
  always_ff @(posedge clock) begin
    if (reset)     last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  end

endmodule

// File: rtl/clusterv_flash_ctrl.sv
// Shares one SPI flash between two Wishbone read initiators; one SPI READ per word, ack at 1+64*2*CLK_DIV
// (1+72*2*CLK_DIV with CLUSTERV_FLASH_FAST_READ_EN); the losing initiator holds stb until served.
module clusterv_flash_ctrl
  import clusterv_flash_pkg::*;
#(
  parameter int FLASH_AW = 24,
  parameter int CLK_DIV  = 1
) (
  input  logic              clock,
  input  logic              reset,
  clusterv_flash_if.slave   i0,
  clusterv_flash_if.slave   i1,
  output logic              flash_sck,
  output logic              flash_csn,
  output logic              flash_sdo,
  input  logic              flash_sdi
);

`ifdef CLUSTERV_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = FLASH_CMD_FAST_READ;
`else
  localparam logic [7:0] READ_CMD = FLASH_CMD_READ;
`endif
  localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [4:0] GAP_LAST = 5'(2 * CLK_DIV - 1);

  flash_state_e  state;
  flash_state_e  next_phase;
  logic [6:0]    phase_last;
  logic [4:0]    div_cnt;
  logic [6:0]    bit_cnt;
  logic [31:0]   tx_q;
  logic [31:0]   rx_q;
  logic [31:0]   dat_q;
  logic          gnt_port;
  logic          ack0_q, ack1_q, err0_q, err1_q;
  logic          sck_q, csn_q, sdo_q;

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                last_grant;
  logic                gnt_we;
  logic [FLASH_AW-1:2] gnt_adr;
  logic                cur_req;
  logic                unused_bits;

  assign req     = {i1.cyc & i1.stb, i0.cyc & i0.stb};
  assign gnt_we  = gnt[1] ? i1.we : i0.we;
  assign gnt_adr = gnt[1] ? i1.adr[FLASH_AW-1:2] : i0.adr[FLASH_AW-1:2];
  assign cur_req = gnt_port ? req[1] : req[0];
  assign unused_bits = ^{i0.sel, i1.sel, i0.adr[31:FLASH_AW], i0.adr[1:0],
                         i1.adr[31:FLASH_AW], i1.adr[1:0], last_grant};

  clusterv_flash_arb u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .enable     (state == IDLE),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  always_comb begin
    phase_last = 7'd0;
    next_phase = IDLE;
    case (state)
      CMD:   begin phase_last = CMD_BITS - 7'd1;   next_phase = ADDR; end
`ifdef CLUSTERV_FLASH_FAST_READ_EN
      ADDR:  begin phase_last = ADDR_BITS - 7'd1;  next_phase = DUMMY; end
`else
      ADDR:  begin phase_last = ADDR_BITS - 7'd1;  next_phase = DATA; end
`endif
      DUMMY: begin phase_last = DUMMY_BITS - 7'd1; next_phase = DATA; end
      DATA:  begin phase_last = DATA_BITS - 7'd1;  next_phase = ACK; end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= 5'd0;
      bit_cnt  <= 7'd0;
      tx_q     <= 32'd0;
      rx_q     <= 32'd0;
      dat_q    <= 32'd0;
      gnt_port <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      sck_q    <= 1'b0;
      csn_q    <= 1'b1;
      sdo_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            gnt_port <= gnt[1];
            div_cnt  <= 5'd0;
            bit_cnt  <= 7'd0;
            if (gnt_we) begin
              err0_q <= gnt[0];
              err1_q <= gnt[1];
              state  <= GAP;
            end else begin
              csn_q <= 1'b0;
              tx_q  <= {READ_CMD, gnt_adr, 2'b00};
              sdo_q <= READ_CMD[7];
              state <= CMD;
            end
          end
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 5'd0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              if (state == DATA) rx_q <= {rx_q[30:0], flash_sdi};
            end else begin
              // Falling edge closes the bit; sdo moves on while sck is low.
              sck_q <= 1'b0;
              tx_q  <= {tx_q[30:0], 1'b0};
              if (bit_cnt == phase_last) begin
                bit_cnt <= 7'd0;
                state   <= next_phase;
                sdo_q   <= (state == CMD) ? tx_q[30] : 1'b0;
                if (state == DATA) begin
                  csn_q <= 1'b1;
                  if (cur_req) begin
                    dat_q  <= bswap32(rx_q);
                    ack0_q <= !gnt_port;
                    ack1_q <= gnt_port;
                  end
                end
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
                sdo_q   <= (state == CMD || state == ADDR) ? tx_q[30] : 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 5'd1;
          end
        end
        ACK: begin
          div_cnt <= 5'd0;
          state   <= GAP;
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= 5'd0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i0.ack   = ack0_q;
  assign i1.ack   = ack1_q;
  assign i0.err   = err0_q;
  assign i1.err   = err1_q;
  assign i0.dat_r = dat_q;
  assign i1.dat_r = dat_q;
  assign flash_sck = sck_q;
  assign flash_csn = csn_q;
  assign flash_sdo = sdo_q;

endmodule

// File: tb/tb_clusterv_flash_ctrl.sv
// Directed bench: two controllers (CLK_DIV 1 and 3), each with a mode-0 SPI flash model.
module tb_clusterv_flash_ctrl;

`ifdef CLUSTERV_FLASH_FAST_READ_EN
  localparam int         TOTAL_BITS = 72;
  localparam logic [7:0] EXP_CMD    = 8'h0B;
`else
  localparam int         TOTAL_BITS = 64;
  localparam logic [7:0] EXP_CMD    = 8'h03;
`endif
  localparam int DSTART = TOTAL_BITS - 32;
  localparam int LAT1   = 1 + TOTAL_BITS * 2 * 1;
  localparam int LAT3   = 1 + TOTAL_BITS * 2 * 3;

  typedef struct {
    int          ack_at;
    int          err_at;
    int          lo_at;
    int          hi_at;
    int          rise1;
    int          rise2;
    logic        sck_hi;
    logic [31:0] dat;
    logic        done;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] adr_v  [2][2];
  logic        cyc_v  [2][2];
  logic        stb_v  [2][2];
  logic        we_v   [2][2];
  logic        ack_v  [2][2];
  logic        err_v  [2][2];
  logic [31:0] dat_v  [2][2];
  int          nack_v [2][2];
  logic        csn_v  [2];
  logic        sck_v  [2];
  logic        sdo_v  [2];
  logic [31:0] rx_v   [2];
  int          rise_v [2];
  int          fall_v [2];
  logic [7:0]  fb     [4];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    clusterv_flash_if i0b ();
    clusterv_flash_if i1b ();
    logic        sck, csn, sdo;
    logic        sdi = 1'b0;
    int          fcnt = 0;
    int          fk = 0;
    logic [31:0] frx = 32'd0;
    int          frise = 0, nfall = 0, nack0 = 0, nack1 = 0;

    assign i0b.adr = adr_v[d][0];
    assign i0b.cyc = cyc_v[d][0];
    assign i0b.stb = stb_v[d][0];
    assign i0b.we  = we_v[d][0];
    assign i0b.sel = 4'hF;
    assign i1b.adr = adr_v[d][1];
    assign i1b.cyc = cyc_v[d][1];
    assign i1b.stb = stb_v[d][1];
    assign i1b.we  = we_v[d][1];
    assign i1b.sel = 4'hF;

    clusterv_flash_ctrl #(.FLASH_AW(24), .CLK_DIV(d == 0 ? 1 : 3)) dut (
      .clock     (clock),
      .reset     (reset),
      .i0        (i0b),
      .i1        (i1b),
      .flash_sck (sck),
      .flash_csn (csn),
      .flash_sdo (sdo),
      .flash_sdi (sdi)
    );

    assign ack_v[d][0]  = i0b.ack;
    assign ack_v[d][1]  = i1b.ack;
    assign err_v[d][0]  = i0b.err;
    assign err_v[d][1]  = i1b.err;
    assign dat_v[d][0]  = i0b.dat_r;
    assign dat_v[d][1]  = i1b.dat_r;
    assign nack_v[d][0] = nack0;
    assign nack_v[d][1] = nack1;
    assign csn_v[d]  = csn;
    assign sck_v[d]  = sck;
    assign sdo_v[d]  = sdo;
    assign rx_v[d]   = frx;
    assign rise_v[d] = frise;
    assign fall_v[d] = nfall;

    // Flash side: capture command/address on rising sck, drive data after falling sck.
    always @(posedge sck or posedge csn) begin
      if (csn) fcnt <= 0;
      else begin
        if (fcnt < 32) frx <= {frx[30:0], sdo};
        fcnt <= fcnt + 1;
      end
    end
    always @(negedge sck) begin
      if (!csn && fcnt >= DSTART && fcnt < DSTART + 32) begin
        fk = fcnt - DSTART;
        sdi <= fb[fk / 8][7 - (fk % 8)];
      end
    end
    always @(posedge sck) frise++;
    always @(negedge csn) nfall++;
    always @(posedge clock) begin
      if (i0b.ack) nack0++;
      if (i1b.ack) nack1++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issue one request at cycle 0 and follow it until ack, err or csn release.
  task automatic xfer(input int d, input int p, input logic [31:0] adr, input logic we,
                      input int drop_at, input int rst_at, output res_t r);
    logic prev_sck;
    r.ack_at = -1; r.err_at = -1; r.lo_at = -1; r.hi_at = -1;
    r.rise1 = -1; r.rise2 = -1; r.sck_hi = 1'bx; r.dat = 32'hx; r.done = 1'b0;
    prev_sck = sck_v[d];
    adr_v[d][p] = adr;
    we_v[d][p]  = we;
    cyc_v[d][p] = 1'b1;
    stb_v[d][p] = 1'b1;
    for (int n = 1; n <= 1500 && !r.done; n++) begin
      @(posedge clock);
      #1;
      if (reset) reset = 1'b0;
      if (n == drop_at || n == rst_at) begin
        cyc_v[d][p] = 1'b0;
        stb_v[d][p] = 1'b0;
      end
      if (n == rst_at) reset = 1'b1;
      if (sck_v[d] && !prev_sck) begin
        if (r.rise1 < 0) r.rise1 = n;
        else if (r.rise2 < 0) r.rise2 = n;
      end
      prev_sck = sck_v[d];
      if (!csn_v[d] && r.lo_at < 0) r.lo_at = n;
      if (ack_v[d][p]) begin
        r.ack_at = n;
        r.dat = dat_v[d][p];
        r.done = 1'b1;
      end else if (err_v[d][p]) begin
        r.err_at = n;
        r.done = 1'b1;
      end else if (r.lo_at > 0 && csn_v[d]) begin
        r.hi_at = n;
        r.sck_hi = sck_v[d];
        r.done = 1'b1;
      end
      if (r.done) begin
        cyc_v[d][p] = 1'b0;
        stb_v[d][p] = 1'b0;
      end
    end
    chk("xfer_done", 32'(r.done), 32'd1);
  endtask

  initial begin
    res_t r;
    int   base_a, base_b, got;
    int   order[$];

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        adr_v[d][p] = 32'd0; cyc_v[d][p] = 1'b0; stb_v[d][p] = 1'b0; we_v[d][p] = 1'b0;
      end
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;

    // Reset values
    idle(3);
    for (int d = 0; d < 2; d++) begin
      chk("rst_csn", 32'(csn_v[d]), 32'd1);
      chk("rst_sck", 32'(sck_v[d]), 32'd0);
      chk("rst_sdo", 32'(sdo_v[d]), 32'd0);
      for (int p = 0; p < 2; p++) begin
        chk("rst_ack", 32'(ack_v[d][p]), 32'd0);
        chk("rst_err", 32'(err_v[d][p]), 32'd0);
        chk("rst_dat", dat_v[d][p], 32'd0);
      end
    end
    reset = 1'b0;
    idle(2);

    // Basic read on CLK_DIV=1
    xfer(0, 0, 32'h0000_0100, 1'b0, -1, -1, r);
    chk("t1_csn_fall", 32'(r.lo_at), 32'd1);
    chk("t1_ack_cycle", 32'(r.ack_at), 32'(LAT1));
    chk("t1_dat", r.dat, 32'h4433_2211);
    chk("t1_csn_at_ack", 32'(csn_v[0]), 32'd1);
    chk("t1_sdo_stream", rx_v[0], {EXP_CMD, 24'h000100});
    chk("t1_rise1", 32'(r.rise1), 32'd2);
    chk("t1_rise2", 32'(r.rise2), 32'd4);
    chk("t1_i1_ack", 32'(nack_v[0][1]), 32'd0);
    idle(1);
    chk("t1_ack_pulse", 32'(ack_v[0][0]), 32'd0);
    idle(20);

    // Write is rejected without touching the flash
    base_a = fall_v[0];
    base_b = rise_v[0];
    xfer(0, 1, 32'h0000_0000, 1'b1, -1, -1, r);
    chk("t3_err_cycle", 32'(r.err_at), 32'd1);
    chk("t3_i0_err", 32'(err_v[0][0]), 32'd0);
    idle(1);
    chk("t3_err_pulse", 32'(err_v[0][1]), 32'd0);
    idle(20);
    chk("t3_no_csn", 32'(fall_v[0] - base_a), 32'd0);
    chk("t3_no_sck", 32'(rise_v[0] - base_b), 32'd0);

    // Contention from reset: strict alternation i0,i1,i0,i1
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    for (int round = 0; round < 2; round++) begin
      adr_v[0][0] = 32'h0000_0200; we_v[0][0] = 1'b0; cyc_v[0][0] = 1'b1; stb_v[0][0] = 1'b1;
      adr_v[0][1] = 32'h0000_0300; we_v[0][1] = 1'b0; cyc_v[0][1] = 1'b1; stb_v[0][1] = 1'b1;
      got = 0;
      for (int n = 0; n < 1000 && got < 2; n++) begin
        @(posedge clock);
        #1;
        for (int p = 0; p < 2; p++)
          if (ack_v[0][p]) begin
            order.push_back(p);
            cyc_v[0][p] = 1'b0;
            stb_v[0][p] = 1'b0;
            got++;
          end
      end
      cyc_v[0][0] = 1'b0; stb_v[0][0] = 1'b0; cyc_v[0][1] = 1'b0; stb_v[0][1] = 1'b0;
      idle(10);
    end
    chk("t2_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));

    // CLK_DIV=3 read, address low bits and upper byte ignored
    fb[0] = 8'hDE; fb[1] = 8'hAD; fb[2] = 8'hBE; fb[3] = 8'hEF;
    xfer(1, 0, 32'hFF12_3457, 1'b0, -1, -1, r);
    chk("t4_ack_cycle", 32'(r.ack_at), 32'(LAT3));
    chk("t4_dat", r.dat, 32'hEFBE_ADDE);
    chk("t4_sdo_stream", rx_v[1], {EXP_CMD, 24'h123454});
    chk("t4_rise1", 32'(r.rise1), 32'd4);
    chk("t4_sck_period", 32'(r.rise2 - r.rise1), 32'd6);
    idle(20);

    // Reset during DATA aborts cleanly, then a fresh read works
    base_a = nack_v[0][0];
    xfer(0, 0, 32'h0000_0040, 1'b0, -1, 100, r);
    chk("t5_csn_release", 32'(r.hi_at), 32'd101);
    chk("t5_sck_low", 32'(r.sck_hi), 32'd0);
    chk("t5_no_ack", 32'(r.ack_at), 32'hFFFF_FFFF);
    idle(300);
    chk("t5_no_late_ack", 32'(nack_v[0][0] - base_a), 32'd0);
    fb[0] = 8'hA5; fb[1] = 8'h5A; fb[2] = 8'hF0; fb[3] = 8'h0F;
    xfer(0, 0, 32'h0000_0080, 1'b0, -1, -1, r);
    chk("t5_retry_ack", 32'(r.ack_at), 32'(LAT1));
    chk("t5_retry_dat", r.dat, 32'h0FF0_5AA5);
    idle(20);

    // Initiator abandons the cycle: SPI runs to completion, no ack
    base_a = nack_v[0][0];
    xfer(0, 0, 32'h0000_0010, 1'b0, 50, -1, r);
    chk("t6_no_ack", 32'(r.ack_at), 32'hFFFF_FFFF);
    chk("t6_csn_release", 32'(r.hi_at), 32'(LAT1));
    idle(20);
    chk("t6_no_late_ack", 32'(nack_v[0][0] - base_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
